// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle instruction sequencer. A run fetches PROG_LEN words from a
// synchronous instruction memory, starting at address 0. Each word is decoded,
// its operands are read from an external register file, it is executed on an
// external combinational ALU, and the result is written back. Every
// instruction takes exactly four cycles: FETCH, DECODE, EXEC, WB.
//
// Instruction word:
//   [31:21] reserved (must be 0)   [20:16] src A   [15:11] src B
//   [10:6]  dest                   [5:0]   opcode
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, honoured only in IDLE or HALT
//   busy                high in FETCH, DECODE, EXEC, WB
//   done                one-cycle pulse on entry to HALT
//   err                 sticky illegal-instruction flag (trap build only)
//   imem_addr/rdata     instruction memory (data valid one cycle after addr)
//   rf_ra1/ra2/rd1/rd2  register-file combinational read ports
//   rf_we/wa/wd         register-file write port (WB only)
//   alu_opcode/a/b      ALU operands, driven in EXEC only
//   alu_result          ALU result, captured at the end of EXEC
//   retired             instructions completed in the current run (saturating)
//
// Build macro
//   SEQ_ILLEGAL_TRAP_EN  defined: an illegal instruction sets err, is not
//                        written or retired, and ends the run in HALT.
//                        undefined: illegal instructions behave as NOPs.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PROG_LEN = 12,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [4:0]        rf_ra1,
  output logic [4:0]        rf_ra2,
  input  logic [31:0]       rf_rd1,
  input  logic [31:0]       rf_rd2,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [31:0]       rf_wd,
  output logic [5:0]        alu_opcode,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_result,
  output logic [15:0]       retired
);

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         res_q, res_d;
  logic [15:0]         retired_q, retired_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  // ---------------------------------------------------------------------------
  // Decode of the held instruction word
  // ---------------------------------------------------------------------------
  logic rsvd_zero;
  logic is_alu;
  logic is_nop;
  logic is_illegal;

  assign rsvd_zero = (ir_q[31:21] == 11'd0);

  always_comb begin
    // NOTE: every variable written in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    is_alu = 1'b0;
    unique case (ir_q[5:0])
      6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: is_alu = rsvd_zero;
      default:                           is_alu = 1'b0;
    endcase
  end

  assign is_nop     = rsvd_zero && (ir_q[5:0] == 6'h00);
  assign is_illegal = !is_alu && !is_nop;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    res_d      = res_q;
    retired_d  = retired_q;
    err_d      = err_q;
    done_d     = 1'b0;

    imem_addr  = '0;
    rf_ra1     = 5'd0;
    rf_ra2     = 5'd0;
    rf_we      = 1'b0;
    rf_wa      = 5'd0;
    rf_wd      = 32'd0;
    alu_opcode = 6'd0;
    alu_a      = 32'd0;
    alu_b      = 32'd0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          retired_d = 16'd0;
          err_d     = 1'b0;
        end
      end

      S_FETCH: begin
        imem_addr = pc_q;
        state_d   = S_DECODE;
      end

      S_DECODE: begin
        ir_d    = imem_rdata;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        rf_ra1     = ir_q[20:16];
        rf_ra2     = ir_q[15:11];
        alu_opcode = ir_q[5:0];
        alu_a      = rf_rd1;
        alu_b      = rf_rd2;
        // Operands are read before the WB of this instruction, so a
        // destination that is also a source sees its old value.
        res_d      = alu_result;
        state_d    = S_WB;
      end

      S_WB: begin
        if (TrapEn && is_illegal) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          if (is_alu) begin
            rf_we = 1'b1;
            rf_wa = ir_q[10:6];
            rf_wd = res_q;
          end
          retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
          pc_d      = pc_q + ADDR_W'(1);
          if (pc_q == LastPc) begin
            done_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  // NOTE: IR and RES are datapath registers but are still reset, so a run
  // aborted by reset leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= 32'd0;
      res_q     <= 32'd0;
      retired_q <= 16'd0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      res_q     <= res_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                   (state_q == S_EXEC)  || (state_q == S_WB);
  assign done    = done_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Bench for instr_sequencer: provides a synchronous instruction memory, a
// 32-entry register file and a combinational ALU (05 add, 02 sub, 03 abs,
// 04 neg, 06 signed max, 07 signed min, 08 average, 0A not, 0C or, 0D and,
// 0F xor). Single-instruction behaviour comes from a vector table; full runs,
// reset mid-instruction and the illegal-instruction trap are hand sequences.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int PROG_LEN = 12;
  localparam int ADDR_W   = 4;

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam logic [15:0] ILL_RET = 16'd0;
  localparam logic        ILL_ERR = 1'b1;
`else
  localparam logic [15:0] ILL_RET = 16'd1;
  localparam logic        ILL_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy, done, err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [4:0]        rf_ra1, rf_ra2;
  logic [31:0]       rf_rd1, rf_rd2;
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [31:0]       rf_wd;
  logic [5:0]        alu_opcode;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic [15:0]       retired;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.PROG_LEN(PROG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .retired    (retired)
  );

  // Instruction memory: synchronous read
  logic [31:0] mem [16];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  // Register file: combinational read, write at clock edge; tb_load
  // restores the initial contents (R1=1208, R2=2D78, rest 0).
  logic        tb_load = 1'b0;
  logic [31:0] rf [32];
  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[1] <= 32'h0000_1208;
      rf[2] <= 32'h0000_2D78;
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  // ALU
  always_comb begin
    alu_result = 32'd0;
    case (alu_opcode)
      6'h05: alu_result = alu_a + alu_b;
      6'h02: alu_result = alu_a - alu_b;
      6'h03: alu_result = alu_a[31] ? (32'd0 - alu_a) : alu_a;
      6'h04: alu_result = 32'd0 - alu_a;
      6'h06: alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      6'h07: alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      6'h08: alu_result = 32'((33'(alu_a) + 33'(alu_b)) >> 1);
      6'h0A: alu_result = ~alu_a;
      6'h0C: alu_result = alu_a | alu_b;
      6'h0D: alu_result = alu_a & alu_b;
      6'h0F: alu_result = alu_a ^ alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  function automatic logic [31:0] enc(input logic [4:0] a, input logic [4:0] b,
                                      input logic [4:0] d, input logic [5:0] op);
    return {11'h0, a, b, d, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
  endtask

  // Reset with register-file reload; returns 1 time unit after an edge.
  task automatic do_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    tb_load = 1'b1;
    @(posedge clk);
    #1;
    tb_load = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Returns in the first cycle after the edge that samples start (FETCH).
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from the start-sampling edge until done is seen.
  task automatic wait_done(input string tag, input int hold,
                           output int edges, output int writes);
    bit seen;
    seen   = 1'b0;
    edges  = 0;
    writes = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (edges == hold) start = 1'b0;
      @(posedge clk);
      #1;
      edges++;
      if (rf_we) writes++;
      if (done) seen = 1'b1;
    end
    check({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  typedef struct packed {
    logic [31:0] word;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic [15:0] exp_ret;
    logic        exp_err;
  } vec_t;

  localparam int NV = 10;
  vec_t        vec [NV];
  logic [31:0] exp_rf [14];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int edges;
    int writes;

    vec[0] = '{enc(5'd1, 5'd2, 5'd1,  6'h05), 1'b1, 5'd1,  32'h0000_3F80, 16'd1, 1'b0};
    vec[1] = '{enc(5'd2, 5'd1, 5'd4,  6'h02), 1'b1, 5'd4,  32'h0000_1B70, 16'd1, 1'b0};
    vec[2] = '{enc(5'd1, 5'd2, 5'd13, 6'h0F), 1'b1, 5'd13, 32'h0000_3F70, 16'd1, 1'b0};
    vec[3] = '{enc(5'd1, 5'd2, 5'd12, 6'h0D), 1'b1, 5'd12, 32'h0000_0008, 16'd1, 1'b0};
    vec[4] = '{enc(5'd1, 5'd0, 5'd10, 6'h0A), 1'b1, 5'd10, 32'hFFFF_EDF7, 16'd1, 1'b0};
    vec[5] = '{32'h0000_0000,                 1'b0, 5'd0,  32'h0,         16'd1, 1'b0};
    vec[6] = '{enc(5'd1, 5'd2, 5'd3,  6'h01), 1'b0, 5'd0,  32'h0,         ILL_RET, ILL_ERR};
    vec[7] = '{enc(5'd1, 5'd2, 5'd3,  6'h05) | 32'h0020_0000,
                                              1'b0, 5'd0,  32'h0,         ILL_RET, ILL_ERR};
    vec[8] = '{enc(5'd1, 5'd2, 5'd3,  6'h3F), 1'b0, 5'd0,  32'h0,         ILL_RET, ILL_ERR};
    vec[9] = '{32'h8000_0000,                 1'b0, 5'd0,  32'h0,         ILL_RET, ILL_ERR};

    exp_rf[0]  = 32'h0;          exp_rf[1]  = 32'h0000_1208;
    exp_rf[2]  = 32'h0000_2D78;  exp_rf[3]  = 32'h0000_3F80;
    exp_rf[4]  = 32'h0000_1B70;  exp_rf[5]  = 32'hFFFF_EDF8;
    exp_rf[6]  = 32'h0000_1208;  exp_rf[7]  = 32'h0000_3F80;
    exp_rf[8]  = 32'h0000_1B70;  exp_rf[9]  = 32'h0000_2D78;
    exp_rf[10] = 32'hFFFF_EDF7;  exp_rf[11] = 32'h0000_3F78;
    exp_rf[12] = 32'h0000_0008;  exp_rf[13] = 32'h0000_3F70;

    rst_n = 1'b0;
    start = 1'b0;
    clear_mem();
    do_reset();

    // Reset state
    check("reset_ctrl", {28'd0, busy, done, err, rf_we}, 32'd0);
    check("reset_retired", {16'd0, retired}, 32'd0);

    // Single-instruction vectors: WB in the 4th cycle, then retire/err status.
    for (int i = 0; i < NV; i++) begin
      clear_mem();
      mem[0] = vec[i].word;
      do_reset();
      pulse_start();
      cycles(3);
      check($sformatf("vec%0d_we", i), {31'd0, rf_we}, {31'd0, vec[i].exp_we});
      if (vec[i].exp_we) begin
        check($sformatf("vec%0d_wa", i), {27'd0, rf_wa}, {27'd0, vec[i].exp_wa});
        check($sformatf("vec%0d_wd", i), rf_wd, vec[i].exp_wd);
      end
      cycles(1);
      check($sformatf("vec%0d_retired", i), {16'd0, retired}, {16'd0, vec[i].exp_ret});
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vec[i].exp_err});
    end

    // Full 12-word program with start held high for the first 20 cycles.
    clear_mem();
    mem[0]  = enc(5'd1, 5'd2, 5'd3,  6'h05);
    mem[1]  = enc(5'd2, 5'd1, 5'd4,  6'h02);
    mem[2]  = enc(5'd1, 5'd0, 5'd5,  6'h04);
    mem[3]  = enc(5'd5, 5'd0, 5'd6,  6'h03);
    mem[4]  = enc(5'd3, 5'd4, 5'd7,  6'h06);
    mem[5]  = enc(5'd3, 5'd4, 5'd8,  6'h07);
    mem[6]  = enc(5'd3, 5'd4, 5'd9,  6'h08);
    mem[7]  = enc(5'd1, 5'd0, 5'd10, 6'h0A);
    mem[8]  = enc(5'd1, 5'd2, 5'd11, 6'h0C);
    mem[9]  = enc(5'd1, 5'd2, 5'd12, 6'h0D);
    mem[10] = enc(5'd1, 5'd2, 5'd13, 6'h0F);
    mem[11] = 32'h0;
    do_reset();
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done("prog1", 19, edges, writes);
    check("prog1_done_edge", 32'(edges), 32'd48);
    check("prog1_writes", 32'(writes), 32'd11);
    check("prog1_retired", {16'd0, retired}, 32'd12);
    check("prog1_status", {29'd0, busy, done, err}, 32'b010);
    for (int r = 3; r < 14; r++)
      check($sformatf("prog1_R%0d", r), rf[r], exp_rf[r]);
    cycles(1);
    check("prog1_done_pulse", {30'd0, busy, done}, 32'd0);

    // Start accepted in HALT: new run from pc 0 with retired cleared.
    pulse_start();
    check("rerun_first", {11'd0, busy, imem_addr, retired}, {11'd0, 1'b1, 4'd0, 16'd0});
    wait_done("prog2", 0, edges, writes);
    check("prog2_done_edge", 32'(edges), 32'd48);
    check("prog2_retired", {16'd0, retired}, 32'd12);
    check("prog2_R13", rf[13], 32'h0000_3F70);

    // Reset during EXEC of the second instruction.
    clear_mem();
    mem[0] = enc(5'd1, 5'd2, 5'd3, 6'h05);
    mem[1] = enc(5'd2, 5'd1, 5'd4, 6'h02);
    do_reset();
    pulse_start();
    cycles(6);
    check("rst_pre_exec", {10'd0, alu_opcode, retired}, {10'd0, 6'h02, 16'd1});
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", {7'd0, busy, done, err, rf_we, rf_wa, rf_ra1, rf_ra2, alu_opcode}, 32'd0);
    check("rst_cnt", {12'd0, imem_addr, retired}, 32'd0);
    check("rst_data", alu_a | alu_b | rf_wd, 32'd0);
    cycles(2);
    check("rst_no_write", rf[4], 32'd0);
    rst_n = 1'b1;
    cycles(3);
    check("rst_no_resume", {31'd0, busy}, 32'd0);
    pulse_start();
    cycles(3);
    check("rst_rerun_wb0", {rf_we, 26'd0, rf_wa}, {1'b1, 26'd0, 5'd3});
    check("rst_rerun_wd0", rf_wd, 32'h0000_3F80);
    cycles(4);
    check("rst_rerun_wd1", rf_wd, 32'h0000_1B70);

    // Illegal opcode 01 at pc 0.
    clear_mem();
    mem[0] = enc(5'd1, 5'd2, 5'd3, 6'h01);
    do_reset();
    pulse_start();
    cycles(3);
    check("ill_no_write", {31'd0, rf_we}, 32'd0);
    cycles(1);
`ifdef SEQ_ILLEGAL_TRAP_EN
    check("trap_status", {29'd0, busy, done, err}, 32'b011);
    cycles(3);
    check("trap_sticky", {29'd0, busy, done, err}, 32'b001);
    check("trap_no_write", rf[3], 32'd0);
    pulse_start();
    check("trap_err_clear", {30'd0, busy, err}, 32'b10);
`else
    check("ill_continue", {26'd0, busy, done, err, imem_addr}, {26'd0, 1'b1, 1'b0, 1'b0, 4'd1});
    wait_done("ill_run", 0, edges, writes);
    check("ill_retired", {16'd0, retired}, 32'd12);
    check("ill_err", {31'd0, err}, 32'd0);
    check("ill_R3", rf[3], 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
